// File: rtl/decoder3to8_pulse.sv
// Registered 3-to-8 decoder with hold/gap pulse timing and a one-entry pending buffer.
// Drives one-hot strobe lines for HOLD cycles, then GAP zero cycles between codes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing driven, y=0, ready to start on the next accepted code
// DRIVE | y = 1<<code_out, cnt counts down the remaining hold cycles
// GAP   | y=0 dead time between codes, cnt counts down remaining gap cycles
module decoder3to8_pulse #(
   parameter int unsigned HOLD = 4,
   parameter int unsigned GAP  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] a,
   input  logic       flush,
   output logic [7:0] y,
   output logic [2:0] code_out,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
   localparam logic [7:0] GAP_M1  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
   localparam bit         HAS_GAP = (GAP != 0);

   state_t     state;
   logic [7:0] cnt;
   logic [2:0] pend_code;
   logic       pend_v;

   logic       accept;
   logic       cnt_zero;
   logic       next_avail;
   logic       load_next;
   logic [2:0] next_code;

   assign in_ready   = !pend_v;
   assign accept     = in_valid && in_ready && !flush;
   assign cnt_zero   = (cnt == 8'd0);
   assign next_avail = pend_v || accept;
   assign next_code  = pend_v ? pend_code : a;

   // A new code starts on the terminal count of GAP, or of DRIVE when there is no gap.
   assign load_next = cnt_zero && next_avail &&
                      ((state == ST_GAP) || ((state == ST_DRIVE) && !HAS_GAP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         pend_code <= 3'd0;
         pend_v    <= 1'b0;
         y         <= 8'd0;
         code_out  <= 3'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else if (flush) begin
         state    <= ST_IDLE;
         cnt      <= 8'd0;
         pend_v   <= 1'b0;
         y        <= 8'd0;
         code_out <= 3'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;

         // A code consumed on the same edge it is accepted never touches the buffer.
         if (load_next && pend_v) begin
            pend_v <= 1'b0;
         end else if (accept && (state != ST_IDLE) && !load_next) begin
            pend_v    <= 1'b1;
            pend_code <= a;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state    <= ST_DRIVE;
                  y        <= 8'd1 << a;
                  code_out <= a;
                  cnt      <= HOLD_M1;
                  busy     <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  done <= 1'b1;
                  if (HAS_GAP) begin
                     state    <= ST_GAP;
                     y        <= 8'd0;
                     code_out <= 3'd0;
                     cnt      <= GAP_M1;
                  end else if (load_next) begin
                     y        <= 8'd1 << next_code;
                     code_out <= next_code;
                     cnt      <= HOLD_M1;
                  end else begin
                     state    <= ST_IDLE;
                     y        <= 8'd0;
                     code_out <= 3'd0;
                     busy     <= 1'b0;
                  end
               end
            end
            ST_GAP: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 8'd1;
               end else if (load_next) begin
                  state    <= ST_DRIVE;
                  y        <= 8'd1 << next_code;
                  code_out <= next_code;
                  cnt      <= HOLD_M1;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               cnt      <= 8'd0;
               y        <= 8'd0;
               code_out <= 3'd0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Bench for decoder3to8_pulse: two instances (GAP=1 and GAP=0) share stimulus and are
// checked every cycle against a timestamp-based schedule model plus directed traces.
module tb_decoder3to8_pulse;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] a;
   logic       flush;
   logic [7:0] y_o    [2];
   logic [2:0] co_o   [2];
   logic       rdy_o  [2];
   logic       busy_o [2];
   logic       done_o [2];

   int n_cmp = 0;
   int n_err = 0;
   int done1_cnt = 0;

   decoder3to8_pulse #(.HOLD(HOLD), .GAP(1)) u_dut_g1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]), .a(a),
      .flush(flush), .y(y_o[0]), .code_out(co_o[0]), .busy(busy_o[0]), .done(done_o[0]));

   decoder3to8_pulse #(.HOLD(HOLD), .GAP(0)) u_dut_g0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]), .a(a),
      .flush(flush), .y(y_o[1]), .code_out(co_o[1]), .busy(busy_o[1]), .done(done_o[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Schedule model: each accepted code gets a start edge; everything else follows from it.
   typedef struct {
      int     inst;
      int     code;
      longint acc;
      longint start;
   } rec_t;

   rec_t   q[$];
   longint last_end [2];
   longint e_cnt;

   function automatic int gap_of(input int inst);
      return (inst == 0) ? 1 : 0;
   endfunction

   // Buffer is occupied before edge e if a code accepted earlier has not started yet.
   function automatic logic model_ready(input int inst, input longint e);
      foreach (q[i])
         if (q[i].inst == inst && q[i].acc < e && e <= q[i].start) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_exp(input int inst, input longint e,
                                     output logic [7:0] ey, output logic [2:0] ec,
                                     output logic eb, output logic ed, output logic er);
      longint s;
      ey = 8'd0; ec = 3'd0; eb = 1'b0; ed = 1'b0; er = 1'b1;
      if (!rst_n) return;
      foreach (q[i]) begin
         if (q[i].inst != inst) continue;
         s = q[i].start;
         if (e >= s && e < s + HOLD) begin
            ey = 8'(1 << q[i].code);
            ec = 3'(q[i].code);
         end
         if (e >= s && e < s + HOLD + gap_of(inst)) eb = 1'b1;
         if (e == s + HOLD) ed = 1'b1;
      end
      er = model_ready(inst, e + 1);
   endfunction

   initial begin
      e_cnt = 0;
      last_end[0] = 0;
      last_end[1] = 0;
      forever begin
         @(posedge clk);
         e_cnt++;
         if (!rst_n || flush) begin
            q.delete();
            last_end[0] = 0;
            last_end[1] = 0;
         end else if (in_valid) begin
            for (int k = 0; k < 2; k++) begin
               if (model_ready(k, e_cnt)) begin
                  rec_t r;
                  r.inst  = k;
                  r.code  = int'(a);
                  r.acc   = e_cnt;
                  r.start = (e_cnt > last_end[k]) ? e_cnt : last_end[k];
                  q.push_back(r);
                  last_end[k] = r.start + HOLD + gap_of(k);
               end
            end
         end
         for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].start + HOLD + 4 < e_cnt) q.delete(i);
      end
   end

   initial begin
      logic [7:0] ey;
      logic [2:0] ec;
      logic       eb, ed, er;
      forever begin
         @(negedge clk);
         if (done_o[1]) done1_cnt++;
         for (int k = 0; k < 2; k++) begin
            model_exp(k, e_cnt, ey, ec, eb, ed, er);
            chk($sformatf("m%0d_y", k),    32'(y_o[k]),    32'(ey));
            chk($sformatf("m%0d_code", k), 32'(co_o[k]),   32'(ec));
            chk($sformatf("m%0d_busy", k), 32'(busy_o[k]), 32'(eb));
            chk($sformatf("m%0d_done", k), 32'(done_o[k]), 32'(ed));
            chk($sformatf("m%0d_rdy", k),  32'(rdy_o[k]),  32'(er));
            chk($sformatf("onehot%0d", k), 32'($countones(y_o[k]) <= 1), 32'd1);
         end
      end
   end

   task automatic check_seq(input int inst, input string nm, input logic [7:0] ys[$],
                            input logic ds[$]);
      for (int i = 0; i < ys.size(); i++) begin
         chk($sformatf("%s_y%0d", nm, i), 32'(y_o[inst]), 32'(ys[i]));
         chk($sformatf("%s_done%0d", nm, i), 32'(done_o[inst]), 32'(ds[i]));
         @(negedge clk);
      end
   endtask

   typedef struct {
      logic [2:0] a;
      logic [7:0] y;
   } vec_t;

   initial begin
      vec_t       vecs [8];
      logic [7:0] yq[$];
      logic       dq[$];
      int         k;

      vecs[0] = '{3'd0, 8'h01}; vecs[1] = '{3'd1, 8'h02};
      vecs[2] = '{3'd2, 8'h04}; vecs[3] = '{3'd3, 8'h08};
      vecs[4] = '{3'd4, 8'h10}; vecs[5] = '{3'd5, 8'h20};
      vecs[6] = '{3'd6, 8'h40}; vecs[7] = '{3'd7, 8'h80};

      rst_n = 1'b0; in_valid = 1'b0; a = 3'd0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_y", 32'(y_o[0]), 32'h00);
      chk("rst_rdy", 32'(rdy_o[0]), 32'd1);
      chk("rst_busy", 32'(busy_o[0]), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single code a=5 on the GAP=1 instance
      in_valid = 1'b1; a = 3'd5;
      @(negedge clk);
      in_valid = 1'b0;
      chk("single_code", 32'(co_o[0]), 32'd5);
      yq = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
      dq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      check_seq(0, "single", yq, dq);
      chk("single_idle", 32'(busy_o[0]), 32'd0);
      repeat (2) @(negedge clk);

      // back-to-back 3 then 6, second one buffered
      in_valid = 1'b1; a = 3'd3;
      @(negedge clk);
      a = 3'd6;
      chk("b2b_first", 32'(y_o[0]), 32'h08);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_rdy_low", 32'(rdy_o[0]), 32'd0);
      yq = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
      dq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      check_seq(0, "b2b", yq, dq);
      repeat (3) @(negedge clk);

      // full buffer on the GAP=0 instance: 1, 2, then 7 stalls
      done1_cnt = 0;
      in_valid = 1'b1; a = 3'd1;
      @(negedge clk);
      a = 3'd2;
      chk("fb_first", 32'(y_o[1]), 32'h02);
      @(negedge clk);
      a = 3'd7;
      chk("fb_rdy_low", 32'(rdy_o[1]), 32'd0);
      k = 0;
      while (!rdy_o[1] && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("fb_stall_cycles", 32'(k), 32'd3);
      @(negedge clk);
      in_valid = 1'b0;
      chk("fb_rdy_full_again", 32'(rdy_o[1]), 32'd0);
      yq = '{8'h04, 8'h04, 8'h04, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
      dq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      check_seq(1, "fb", yq, dq);
      @(negedge clk);
      chk("fb_done_pulses", 32'(done1_cnt), 32'd3);
      repeat (3) @(negedge clk);

      // every code one at a time
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = vecs[i].a;
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("vec%0d_y_g1", i), 32'(y_o[0]), 32'(vecs[i].y));
         chk($sformatf("vec%0d_y_g0", i), 32'(y_o[1]), 32'(vecs[i].y));
         chk($sformatf("vec%0d_code", i), 32'(co_o[0]), 32'(vecs[i].a));
         repeat (6) @(negedge clk);
      end

      // flush during DRIVE with a code pending
      in_valid = 1'b1; a = 3'd2;
      @(negedge clk);
      a = 3'd4;
      @(negedge clk);
      in_valid = 1'b0;
      chk("flush_pend", 32'(rdy_o[0]), 32'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_y", 32'(y_o[0]), 32'h00);
      chk("flush_rdy", 32'(rdy_o[0]), 32'd1);
      chk("flush_done", 32'(done_o[0]), 32'd0);
      chk("flush_code", 32'(co_o[0]), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("flush_quiet_y", 32'(y_o[0]), 32'h00);
         chk("flush_quiet_done", 32'(done_o[0]), 32'd0);
      end

      // async reset in the GAP cycle with a code pending
      in_valid = 1'b1; a = 3'd3;
      @(negedge clk);
      a = 3'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("gap_busy", 32'(busy_o[0]), 32'd1);
      chk("gap_pend", 32'(rdy_o[0]), 32'd0);
      chk("gap_g0_drive", 32'(y_o[1]), 32'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_y_g1", 32'(y_o[0]), 32'h00);
      chk("arst_y_g0", 32'(y_o[1]), 32'h00);
      chk("arst_code", 32'(co_o[1]), 32'd0);
      chk("arst_busy", 32'(busy_o[0]), 32'd0);
      chk("arst_done", 32'(done_o[0]), 32'd0);
      chk("arst_rdy", 32'(rdy_o[0]), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; a = 3'd0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("post_rst_y", 32'(y_o[0]), 32'h01);
      repeat (8) @(negedge clk);

      // randomized traffic with occasional flushes, checked by the model
      for (int i = 0; i < 1200; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         a        = 3'($urandom_range(0, 7));
         flush    = ($urandom_range(0, 39) == 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
